// File: rtl/s_pdif_transmitter.sv
// S/PDIF (IEC 60958) 16-bit stereo transmitter: biphase-mark line coder with block framing.
// One Clk_Ena strobe per half-cell; 64 half-cells per subframe, 2 subframes per frame.
module s_pdif_transmitter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Clk_Ena,
  input  logic        Enable,
  input  logic        Audio_Valid,
  input  logic [15:0] Audio_L,
  input  logic [15:0] Audio_R,
  output logic        S_PDIF_Out,
  output logic        Frame_Start,
  output logic        Underrun
);

  localparam logic [7:0] PreB      = 8'b11101000;
  localparam logic [7:0] PreM      = 8'b11100010;
  localparam logic [7:0] PreW      = 8'b11100100;
  localparam logic [7:0] LastFrame = 8'd191;

  logic [5:0]  hc_q, hc_d;
  logic        sf_q, sf_d;
  logic [7:0]  frame_q, frame_d;
  logic        line_q, line_d;
  logic        inv_q, inv_d;
  logic        par_q, par_d;
  logic [15:0] hold_l_q, hold_l_d;
  logic [15:0] hold_r_q, hold_r_d;
  logic        pend_q, pend_d;
  logic [15:0] sh_l_q, sh_l_d;
  logic [15:0] sh_r_q, sh_r_d;
  logic        v_q, v_d;
  logic        fs_q, fs_d;
  logic        ur_q, ur_d;

  logic        load;
  logic [4:0]  slot;
  logic        first_half;
  logic [7:0]  pre_pat;
  logic        pre_bit;
  logic        c_bit;
  logic        data_bit;

  always_comb begin
    load       = Enable && Clk_Ena && (hc_q == 6'd0) && !sf_q;
    slot       = hc_q[5:1];
    first_half = !hc_q[0];
    pre_pat    = sf_q ? PreW : ((frame_q == 8'd0) ? PreB : PreM);
    pre_bit    = pre_pat[~hc_q[2:0]];
    c_bit      = (frame_q == 8'd2) || (frame_q == 8'd25);
  end

  always_comb begin
    data_bit = 1'b0;
    if (slot >= 5'd12 && slot <= 5'd27) begin
      data_bit = sf_q ? sh_r_q[0] : sh_l_q[0];
    end else if (slot == 5'd28) begin
      data_bit = v_q;
    end else if (slot == 5'd30) begin
      data_bit = c_bit;
    end else if (slot == 5'd31) begin
      data_bit = par_q;
    end
  end

  always_comb begin
    hc_d     = hc_q;
    sf_d     = sf_q;
    frame_d  = frame_q;
    line_d   = line_q;
    inv_d    = inv_q;
    par_d    = par_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    pend_d   = pend_q;
    sh_l_d   = sh_l_q;
    sh_r_d   = sh_r_q;
    v_d      = v_q;
    fs_d     = 1'b0;
    ur_d     = 1'b0;

    if (!Enable) begin
      hc_d    = 6'd0;
      sf_d    = 1'b0;
      frame_d = 8'd0;
      line_d  = 1'b0;
    end else if (Clk_Ena) begin
      // Preamble polarity follows the line level left by the previous subframe.
      if (slot < 5'd4) begin
        line_d = pre_bit ^ ((hc_q == 6'd0) ? line_q : inv_q);
      end else if (first_half) begin
        line_d = ~line_q;
      end else begin
        line_d = line_q ^ data_bit;
      end

      if (hc_q == 6'd0) begin
        inv_d = line_q;
        par_d = 1'b0;
      end else if (slot >= 5'd4 && slot <= 5'd30 && first_half) begin
        par_d = par_q ^ data_bit;
      end

      if (!first_half && slot >= 5'd12 && slot <= 5'd27) begin
        if (sf_q) begin
          sh_r_d = {1'b0, sh_r_q[15:1]};
        end else begin
          sh_l_d = {1'b0, sh_l_q[15:1]};
        end
      end

      hc_d = hc_q + 6'd1;
      if (hc_q == 6'd63) begin
        sf_d = ~sf_q;
        if (sf_q) begin
          frame_d = (frame_q == LastFrame) ? 8'd0 : frame_q + 8'd1;
        end
      end
    end

    if (Audio_Valid) begin
      hold_l_d = Audio_L;
      hold_r_d = Audio_R;
      pend_d   = 1'b1;
    end

    // A sample arriving on the load cycle bypasses the holding register.
    if (load) begin
      sh_l_d = Audio_Valid ? Audio_L : hold_l_q;
      sh_r_d = Audio_Valid ? Audio_R : hold_r_q;
      pend_d = 1'b0;
      ur_d   = !pend_q && !Audio_Valid;
      v_d    = !pend_q && !Audio_Valid;
      fs_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hc_q     <= 6'd0;
      sf_q     <= 1'b0;
      frame_q  <= 8'd0;
      line_q   <= 1'b0;
      inv_q    <= 1'b0;
      par_q    <= 1'b0;
      hold_l_q <= 16'd0;
      hold_r_q <= 16'd0;
      pend_q   <= 1'b0;
      sh_l_q   <= 16'd0;
      sh_r_q   <= 16'd0;
      v_q      <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      hc_q     <= hc_d;
      sf_q     <= sf_d;
      frame_q  <= frame_d;
      line_q   <= line_d;
      inv_q    <= inv_d;
      par_q    <= par_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      pend_q   <= pend_d;
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      v_q      <= v_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
    end
  end

  assign S_PDIF_Out  = line_q;
  assign Frame_Start = fs_q;
  assign Underrun    = ur_q;

endmodule

// File: tb/tb_s_pdif_transmitter.sv
// Directed bench for s_pdif_transmitter: a biphase-mark decoder rebuilds each subframe
// from the line and the main sequence compares it with hand-derived expectations.
module tb_s_pdif_transmitter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Clk_Ena = 1'b0;
  logic        Enable = 1'b0;
  logic        Audio_Valid = 1'b0;
  logic [15:0] Audio_L = 16'd0;
  logic [15:0] Audio_R = 16'd0;
  logic        S_PDIF_Out;
  logic        Frame_Start;
  logic        Underrun;

  always #5 Clk = ~Clk;

  s_pdif_transmitter dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Clk_Ena     (Clk_Ena),
    .Enable      (Enable),
    .Audio_Valid (Audio_Valid),
    .Audio_L     (Audio_L),
    .Audio_R     (Audio_R),
    .S_PDIF_Out  (S_PDIF_Out),
    .Frame_Start (Frame_Start),
    .Underrun    (Underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]  pre;
    logic [7:0]  raw_pre;
    logic [7:0]  aux;
    logic [15:0] aud;
    logic        v;
    logic        u;
    logic        c;
    logic        p;
    logic        par_ok;
    logic        bmc_ok;
  } rec_t;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        v;
  } exp_t;

  rec_t recs[$];
  exp_t exp_q[$];
  int   fs_cnt = 0;
  int   ur_cnt = 0;

  function automatic rec_t decode(input logic [63:0] raw, input logic start);
    rec_t        rr;
    logic [31:0] bits;
    int          ones;
    rr        = '0;
    bits      = '0;
    ones      = 0;
    rr.bmc_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rr.raw_pre[7-i] = raw[i];
      rr.pre[7-i]     = raw[i] ^ start;
    end
    for (int s = 4; s < 32; s++) begin
      if (raw[2*s] == raw[2*s-1]) rr.bmc_ok = 1'b0;
      bits[s] = raw[2*s] ^ raw[2*s+1];
      ones += int'(bits[s]);
    end
    rr.aux    = bits[11:4];
    rr.aud    = bits[27:12];
    rr.v      = bits[28];
    rr.u      = bits[29];
    rr.c      = bits[30];
    rr.p      = bits[31];
    rr.par_ok = (ones % 2) == 0;
    return rr;
  endfunction

  // Line collector: one half-cell per enabled strobe, sampled just after the edge.
  logic [63:0] raw_hc;
  int          hc_tb = 0;
  logic        last_line = 1'b0;
  logic        start_lvl = 1'b0;

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (Frame_Start) fs_cnt++;
      if (Underrun) ur_cnt++;
      if (Reset || !Enable) begin
        hc_tb     = 0;
        last_line = 1'b0;
      end else if (Clk_Ena) begin
        if (hc_tb == 0) start_lvl = last_line;
        raw_hc[hc_tb] = S_PDIF_Out;
        last_line     = S_PDIF_Out;
        if (hc_tb == 63) begin
          recs.push_back(decode(raw_hc, start_lvl));
          hc_tb = 0;
        end else begin
          hc_tb++;
        end
      end
    end
  end

  bit en_drv  = 1'b0;
  bit rst_drv = 1'b1;
  bit ena_run = 1'b0;
  bit ena_ph  = 1'b0;

  // Half-cell strobe on every other Clk while running.
  task automatic cyc(input logic av, input logic [15:0] l, input logic [15:0] r);
    @(negedge Clk);
    Reset       = rst_drv;
    Enable      = en_drv;
    Clk_Ena     = ena_run & ena_ph;
    ena_ph      = ~ena_ph;
    Audio_Valid = av;
    Audio_L     = l;
    Audio_R     = r;
  endtask

  logic [15:0] sl, sr;
  logic [7:0]  exp_pre;
  exp_t        e;

  initial begin
    repeat (4) cyc(1'b0, 16'd0, 16'd0);
    check("rst_line", S_PDIF_Out, 1'b0);
    check("rst_frame_start", Frame_Start, 1'b0);
    check("rst_underrun", Underrun, 1'b0);
    rst_drv = 1'b0;
    repeat (2) cyc(1'b0, 16'd0, 16'd0);

    // Sample before the first strobe, then three frames with no new data, then fresh data.
    en_drv = 1'b1;
    exp_q.push_back('{16'h0001, 16'h8000, 1'b0});
    repeat (3) exp_q.push_back('{16'h0001, 16'h8000, 1'b1});
    cyc(1'b1, 16'h0001, 16'h8000);
    ena_run = 1'b1;
    ena_ph  = 1'b1;
    fs_cnt  = 0;
    ur_cnt  = 0;
    recs.delete();
    for (int f = 0; f < 193; f++) begin
      for (int j = 0; j < 256; j++) begin
        if (f >= 3 && f <= 191 && j == 201) begin
          sl = 16'($urandom);
          sr = 16'($urandom);
          exp_q.push_back('{sl, sr, 1'b0});
          cyc(1'b1, sl, sr);
        end else begin
          cyc(1'b0, 16'd0, 16'd0);
        end
      end
      if (f == 0) check("underrun_f0", ur_cnt, 0);
      if (f == 3) check("underrun_f3", ur_cnt, 3);
    end
    check("frame_starts", fs_cnt, 193);
    check("underruns", ur_cnt, 3);
    check("subframes", recs.size(), 386);
    check("p_bit_f0_left", recs[0].p, 1'b1);
    check("p_bit_f0_right", recs[1].p, 1'b1);
    for (int i = 0; i < recs.size() && i < 386; i++) begin
      int f, s;
      f = i / 2;
      s = i % 2;
      e = exp_q[f];
      if (s == 1)            exp_pre = 8'hE4;
      else if (f % 192 == 0) exp_pre = 8'hE8;
      else                   exp_pre = 8'hE2;
      check($sformatf("pre f%0d s%0d", f, s), recs[i].pre, exp_pre);
      check($sformatf("aud f%0d s%0d", f, s), recs[i].aud, (s == 1) ? e.r : e.l);
      check($sformatf("v f%0d s%0d", f, s), recs[i].v, e.v);
      check($sformatf("c f%0d s%0d", f, s), recs[i].c, (f == 2 || f == 25) ? 1'b1 : 1'b0);
      check($sformatf("par f%0d s%0d", f, s), recs[i].par_ok, 1'b1);
      check($sformatf("bmc f%0d s%0d", f, s), recs[i].bmc_ok, 1'b1);
      check($sformatf("aux_u f%0d s%0d", f, s), {recs[i].aux, recs[i].u}, 9'd0);
    end

    // Enable dropped mid-subframe: line idles low.
    repeat (60) cyc(1'b0, 16'd0, 16'd0);
    en_drv = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 16'd0, 16'd0);
      if (k == 5 || k == 20 || k == 39) check($sformatf("idle_line k%0d", k), S_PDIF_Out, 1'b0);
    end

    // Re-enable with a sample coinciding with the load strobe.
    fs_cnt = 0;
    ur_cnt = 0;
    recs.delete();
    en_drv = 1'b1;
    ena_ph = 1'b1;
    for (int j = 0; j < 256; j++) cyc(j == 0, 16'h1234, 16'h5678);
    check("coinc_subframes", recs.size(), 2);
    check("coinc_raw_pre", recs[0].raw_pre, 8'hE8);
    check("coinc_aud_l", recs[0].aud, 16'h1234);
    check("coinc_v_l", recs[0].v, 1'b0);
    check("coinc_pre_r", recs[1].pre, 8'hE4);
    check("coinc_aud_r", recs[1].aud, 16'h5678);
    check("coinc_underrun", ur_cnt, 0);
    check("coinc_frame_start", fs_cnt, 1);

    // Reset mid-subframe: restart with B, V set, cleared samples.
    repeat (100) cyc(1'b0, 16'd0, 16'd0);
    rst_drv = 1'b1;
    repeat (3) cyc(1'b0, 16'd0, 16'd0);
    check("rst_mid_line", S_PDIF_Out, 1'b0);
    rst_drv = 1'b0;
    fs_cnt  = 0;
    ur_cnt  = 0;
    recs.delete();
    ena_ph = 1'b1;
    repeat (256) cyc(1'b0, 16'd0, 16'd0);
    check("rst_subframes", recs.size(), 2);
    check("rst_pre_l", recs[0].pre, 8'hE8);
    check("rst_v_l", recs[0].v, 1'b1);
    check("rst_aud_l", recs[0].aud, 16'h0000);
    check("rst_v_r", recs[1].v, 1'b1);
    check("rst_par_l", recs[0].par_ok, 1'b1);
    check("rst_underrun", ur_cnt, 1);
    check("rst_frame_start", fs_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s_pdif_transmitter.md
S_PDIF_TRANSMITTER -- requirements
Module: s_pdif_transmitter

Interface
REQ-001 SHALL have ports: Clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-002 SHALL have: Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: Clk_Ena  input  1  one-Clk strobe at half-cell rate (128 x Fs; 6.144 MHz at 48 kHz).
REQ-004 SHALL have: Enable  input  1  transmit enable; low = line idle.
REQ-005 SHALL have: Audio_Valid  input  1  one-Clk strobe; Audio_L/Audio_R valid this cycle.
REQ-006 SHALL have: Audio_L  input  16  left sample, two's complement.
REQ-007 SHALL have: Audio_R  input  16  right sample, two's complement.
REQ-008 SHALL have: S_PDIF_Out  output  1  biphase-mark line, registered.
REQ-009 SHALL have: Frame_Start  output  1  one-Clk pulse when a left subframe begins.
REQ-010 SHALL have: Underrun  output  1  one-Clk pulse when a frame starts with no new sample.

Function
REQ-011 SHALL advance all timing state only on Clk cycles with Clk_Ena high; Enable low freezes nothing but forces idle (REQ-025).
REQ-012 SHALL use counters: half-cell 0-63 per subframe, subframe 0 (left) / 1 (right), frame 0-191 per block.
REQ-013 SHALL encode each subframe as 32 slots: slots 0-3 preamble, 4-7 aux = 0, 8-11 = 0, 12-27 audio LSB first, 28 V, 29 U = 0, 30 C, 31 P.
REQ-014 SHALL send preamble B (11101000) on left subframe of frame 0, M (11100010) on other left subframes, W (11100100) on right subframes, as 8 half-cells MSB first.
REQ-015 SHALL XOR the preamble pattern with the line level present before half-cell 0 (invert when line is 1).
REQ-016 SHALL code slots 4-31 biphase-mark: toggle line at every cell start; toggle again mid-cell when bit = 1.
REQ-017 SHALL set P so slots 4-31 contain even number of ones.
REQ-018 SHALL set C = 1 only in frames 2 (copy permitted) and 25 (Fs = 48 kHz), both subframes; else 0.
REQ-019 SHALL latch Audio_L/Audio_R into a holding register on Audio_Valid and set a pending flag.
REQ-020 SHALL at the first Clk_Ena of each left subframe load holding register into L and R shift registers and clear pending.
REQ-021 SHALL, if pending clear at that load, transmit the previous samples with V = 1 in both subframes and pulse Underrun; else V = 0.
REQ-022 SHALL, when Audio_Valid coincides with the load cycle, load the new sample directly and leave pending clear.
REQ-023 SHALL update S_PDIF_Out on the same Clk edge at which Clk_Ena is sampled high (one register stage).
REQ-024 SHALL pulse Frame_Start on the Clk cycle the left load occurs.
REQ-025 SHALL, while Enable low, hold S_PDIF_Out at 0, counters at half-cell 0 / left / frame 0, pending kept; transmission restarts with B preamble at the first Clk_Ena after Enable rises.
REQ-026 SHALL wrap frame counter 191 -> 0, emitting B on the next left subframe.

Reset
REQ-027 SHALL on Reset: S_PDIF_Out = 0, Frame_Start = 0, Underrun = 0, all counters 0, holding and shift registers 0, pending = 0.
REQ-028 SHALL abandon any subframe in progress on Reset mid-operation; first post-reset subframe is a B preamble with V = 1 unless Audio_Valid arrives first.

Verification
REQ-029 Reset, Enable = 1, Audio_Valid with L = 0x0001, R = 0x8000 before first Clk_Ena -> first 8 half-cells 11101000, left slot 12 = 1, V = 0, P = 1; Underrun stays 0.
REQ-030 No Audio_Valid for 3 frames -> Underrun pulses 3 times, V = 1, previous samples repeated.
REQ-031 Run 193 frames -> B preamble at frames 0 and 192 only; C = 1 only in frames 2 and 25.
REQ-032 Audio_Valid on load cycle with L = 0x1234 -> that frame carries 0x1234, V = 0, no Underrun.
REQ-033 Decode output with reference biphase decoder over 1000 random samples -> every cell boundary toggles, all samples and parities match.
REQ-034 Deassert Enable mid-subframe, reassert -> line 0 while low; next data starts with B preamble, inverted correctly per line level.
